// File: rtl/if_player_pkg.sv
// Shared types for the IF pulse player: run modes, FSM states and the
// read-credit helper used to keep the 2-entry output buffer from overflowing.
package if_player_pkg;

   typedef enum logic [1:0] {
      MODE_ONESHOT = 2'd0,
      MODE_BURST   = 2'd1,
      MODE_CONT    = 2'd2,
      MODE_RSVD    = 2'd3
   } mode_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PLAY  = 2'd1,
      ST_GAP   = 2'd2,
      ST_FLUSH = 2'd3
   } state_t;

   localparam int unsigned FIFO_ENTRIES = 2;

   // The reserved encoding runs as a single pulse.
   function automatic mode_t norm_mode(input logic [1:0] raw);
      mode_t m;
      case (raw)
         2'd1:    m = MODE_BURST;
         2'd2:    m = MODE_CONT;
         default: m = MODE_ONESHOT;
      endcase
      return m;
   endfunction

   // A read may be issued only if the buffer will still have room when its
   // data lands one cycle later: occupancy + read in flight - pop this cycle.
   function automatic logic credit_ok(input logic [1:0] count,
                                      input logic       inflight,
                                      input logic       pop);
      logic [2:0] need;
      need = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
      return (need < 3'(FIFO_ENTRIES));
   endfunction

endpackage

// File: rtl/sample_fifo2.sv
// Two-entry FIFO with a registered head so the output stays stable while the
// consumer stalls. Entry 0 is always the head; a pop shifts entry 1 forward.
module sample_fifo2
   import if_player_pkg::*;
#(
   parameter int WIDTH = 14
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_ready,
   output logic             rd_valid,
   output logic [WIDTH-1:0] rd_data,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] mem0_r, mem1_r;
   logic [WIDTH-1:0] mem0_nxt, mem1_nxt;
   logic [1:0]       count_r, count_nxt;
   logic             pop_s;

   assign rd_valid = (count_r != 2'd0);
   assign rd_data  = mem0_r;
   assign count    = count_r;
   assign pop_s    = rd_valid & rd_ready;

   // Next buffer contents for every push/pop combination.
   always_comb begin
      mem0_nxt  = mem0_r;
      mem1_nxt  = mem1_r;
      count_nxt = count_r;
      case ({wr_en, pop_s})
         2'b10: begin
            if (count_r == 2'd0) begin
               mem0_nxt  = wr_data;
               count_nxt = 2'd1;
            end else if (count_r == 2'd1) begin
               mem1_nxt  = wr_data;
               count_nxt = 2'd2;
            end else begin
               // Full: the upstream credit rule never writes here.
               count_nxt = count_r;
            end
         end
         2'b01: begin
            mem0_nxt  = mem1_r;
            count_nxt = count_r - 2'd1;
         end
         2'b11: begin
            if (count_r == 2'd1) begin
               mem0_nxt = wr_data;
            end else begin
               mem0_nxt = mem1_r;
               mem1_nxt = wr_data;
            end
         end
         default: begin
            count_nxt = count_r;
         end
      endcase
   end

   // Buffer storage and occupancy; reset empties the buffer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem0_r  <= '0;
         mem1_r  <= '0;
         count_r <= 2'd0;
      end else begin
         mem0_r  <= mem0_nxt;
         mem1_r  <= mem1_nxt;
         count_r <= count_nxt;
      end
   end

endmodule

// File: rtl/if_pulse_player.sv
// IF pulse player: replays DEPTH samples from a 1-cycle ROM as framed pulses
// (one-shot, burst or continuous) with an optional inter-pulse gap and
// valid/ready backpressure through a 2-entry output buffer.
module if_pulse_player
   import if_player_pkg::*;
#(
   parameter int ADDR_WIDTH  = 11,
   parameter int DATA_WIDTH  = 12,
   parameter int DEPTH       = 1500,
   parameter int CNT_WIDTH   = 16,
   parameter int ROM_LATENCY = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic                         stop,
   input  logic [1:0]                   mode,
   input  logic [CNT_WIDTH-1:0]         num_pulses,
   input  logic [CNT_WIDTH-1:0]         gap_cycles,
   output logic                         rom_en,
   output logic [ADDR_WIDTH-1:0]        rom_addr,
   input  logic signed [DATA_WIDTH-1:0] rom_data,
   output logic signed [DATA_WIDTH-1:0] out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         out_sof,
   output logic                         out_eof,
   output logic [CNT_WIDTH-1:0]         pulse_idx,
   output logic                         busy,
   output logic                         done
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
   localparam int                    FW        = DATA_WIDTH + 2;

   if (ROM_LATENCY != 1 || DEPTH < 2 || DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_params
      $error("if_pulse_player: unsupported parameter set");
   end

   state_t                state_r, state_nxt;
   mode_t                 mode_r, mode_nxt;
   logic [CNT_WIDTH-1:0]  num_r, num_nxt;
   logic [CNT_WIDTH-1:0]  gap_r, gap_nxt;
   logic [CNT_WIDTH-1:0]  gap_cnt_r, gap_cnt_nxt;
   logic [CNT_WIDTH-1:0]  pulse_idx_r, pulse_idx_nxt;
   logic [ADDR_WIDTH-1:0] addr_r, addr_nxt;
   logic                  stop_r, stop_nxt;
   logic                  inflight_r;
   logic                  tag_sof_r, tag_eof_r;

   logic                  issue_s;
   logic                  pop_s;
   logic                  last_addr_s;
   logic                  last_pulse_s;
   logic                  stop_seen_s;
   logic                  drained_s;
   logic                  fifo_valid_s;
   logic [1:0]            fifo_count_s;
   logic [FW-1:0]         fifo_data_s;

   assign pop_s       = fifo_valid_s & out_ready;
   assign last_addr_s = (addr_r == LAST_ADDR);
   assign stop_seen_s = stop | stop_r;
   assign drained_s   = (fifo_count_s == 2'd0) && !inflight_r;

   // Issue a read only in PLAY and only when the buffer has credit.
   always_comb begin
      issue_s = 1'b0;
      if (state_r == ST_PLAY) begin
         issue_s = credit_ok(fifo_count_s, inflight_r, pop_s);
      end else begin
         issue_s = 1'b0;
      end
   end

   // Decide whether the pulse being issued is the final one of the run.
   always_comb begin
      last_pulse_s = 1'b1;
      case (mode_r)
         MODE_BURST: last_pulse_s = (pulse_idx_r == (num_r - CNT_WIDTH'(1)));
         MODE_CONT:  last_pulse_s = 1'b0;
         default:    last_pulse_s = 1'b1;
      endcase
   end

   // Sequencer next-state: run setup, address walk, gap timing and drain.
   always_comb begin
      state_nxt     = state_r;
      mode_nxt      = mode_r;
      num_nxt       = num_r;
      gap_nxt       = gap_r;
      gap_cnt_nxt   = gap_cnt_r;
      pulse_idx_nxt = pulse_idx_r;
      addr_nxt      = addr_r;
      stop_nxt      = stop_r;
      case (state_r)
         ST_IDLE: begin
            stop_nxt = 1'b0;
            if (start) begin
               state_nxt     = ST_PLAY;
               mode_nxt      = norm_mode(mode);
               num_nxt       = (num_pulses == '0) ? CNT_WIDTH'(1) : num_pulses;
               gap_nxt       = gap_cycles;
               gap_cnt_nxt   = '0;
               pulse_idx_nxt = '0;
               addr_nxt      = '0;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_PLAY: begin
            stop_nxt = stop_seen_s;
            if (issue_s && last_addr_s) begin
               addr_nxt = '0;
               if (last_pulse_s || stop_seen_s) begin
                  state_nxt = ST_FLUSH;
               end else if (gap_r != '0) begin
                  state_nxt   = ST_GAP;
                  gap_cnt_nxt = gap_r - CNT_WIDTH'(1);
               end else begin
                  pulse_idx_nxt = pulse_idx_r + CNT_WIDTH'(1);
               end
            end else if (issue_s) begin
               addr_nxt = addr_r + ADDR_WIDTH'(1);
            end else begin
               addr_nxt = addr_r;
            end
         end
         ST_GAP: begin
            stop_nxt = stop_seen_s;
            if (stop_seen_s) begin
               state_nxt = ST_FLUSH;
            end else if (gap_cnt_r == '0) begin
               state_nxt     = ST_PLAY;
               pulse_idx_nxt = pulse_idx_r + CNT_WIDTH'(1);
            end else begin
               gap_cnt_nxt = gap_cnt_r - CNT_WIDTH'(1);
            end
         end
         ST_FLUSH: begin
            if (drained_s) begin
               state_nxt = ST_IDLE;
            end else begin
               state_nxt = ST_FLUSH;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Sequencer state registers; reset aborts any run in progress.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         mode_r      <= MODE_ONESHOT;
         num_r       <= '0;
         gap_r       <= '0;
         gap_cnt_r   <= '0;
         pulse_idx_r <= '0;
         addr_r      <= '0;
         stop_r      <= 1'b0;
      end else begin
         state_r     <= state_nxt;
         mode_r      <= mode_nxt;
         num_r       <= num_nxt;
         gap_r       <= gap_nxt;
         gap_cnt_r   <= gap_cnt_nxt;
         pulse_idx_r <= pulse_idx_nxt;
         addr_r      <= addr_nxt;
         stop_r      <= stop_nxt;
      end
   end

   // Framing tags ride alongside the outstanding ROM read.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         inflight_r <= 1'b0;
         tag_sof_r  <= 1'b0;
         tag_eof_r  <= 1'b0;
      end else begin
         inflight_r <= issue_s;
         tag_sof_r  <= issue_s && (addr_r == '0);
         tag_eof_r  <= issue_s && last_addr_s;
      end
   end

   sample_fifo2 #(
      .WIDTH (FW)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (inflight_r),
      .wr_data  ({rom_data, tag_sof_r, tag_eof_r}),
      .rd_ready (out_ready),
      .rd_valid (fifo_valid_s),
      .rd_data  (fifo_data_s),
      .count    (fifo_count_s)
   );

   assign rom_en    = issue_s;
   assign rom_addr  = addr_r;
   assign out_valid = fifo_valid_s;
   assign out_data  = fifo_data_s[FW-1:2];
   assign out_sof   = fifo_data_s[1];
   assign out_eof   = fifo_data_s[0];
   assign pulse_idx = pulse_idx_r;
   assign busy      = (state_r != ST_IDLE);
   assign done      = (state_r == ST_FLUSH) && drained_s;

endmodule

// File: tb/tb_if_pulse_player.sv
// Directed bench for if_pulse_player with an 8-sample pulse and a behavioural
// 1-cycle ROM. Handshaked samples are logged and compared to hand-built words.
module tb_if_pulse_player;

   localparam int AW = 4;
   localparam int DW = 12;
   localparam int D  = 8;
   localparam int CW = 16;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 start = 1'b0;
   logic                 stop = 1'b0;
   logic [1:0]           mode = 2'd0;
   logic [CW-1:0]        num_pulses = '0;
   logic [CW-1:0]        gap_cycles = '0;
   logic                 rom_en;
   logic [AW-1:0]        rom_addr;
   logic signed [DW-1:0] rom_data = '0;
   logic signed [DW-1:0] out_data;
   logic                 out_valid;
   logic                 out_ready = 1'b1;
   logic                 out_sof, out_eof;
   logic [CW-1:0]        pulse_idx;
   logic                 busy, done;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int done_n = 0;
   int done_c = 0;
   int hold_n = 0;
   logic [13:0] hs_w[$];
   int          hs_c[$];
   int          pidx_q[$];
   logic        stall_r = 1'b0;
   logic [14:0] hold_w = '0;
   int          t0;

   if_pulse_player #(
      .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .DEPTH (D), .CNT_WIDTH (CW), .ROM_LATENCY (1)
   ) dut (
      .clk (clk), .rst_n (rst_n), .start (start), .stop (stop), .mode (mode),
      .num_pulses (num_pulses), .gap_cycles (gap_cycles),
      .rom_en (rom_en), .rom_addr (rom_addr), .rom_data (rom_data),
      .out_data (out_data), .out_valid (out_valid), .out_ready (out_ready),
      .out_sof (out_sof), .out_eof (out_eof), .pulse_idx (pulse_idx),
      .busy (busy), .done (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [11:0] rom_val(input logic [3:0] a);
      return {a, 8'hA5} ^ 12'h800;
   endfunction

   function automatic logic [13:0] exp_word(input int i);
      logic [3:0] a;
      a = i[3:0];
      return {rom_val(a), (i == 0), (i == D - 1)};
   endfunction

   // Synchronous-read ROM model.
   always @(posedge clk) if (rom_en) rom_data <= rom_val(rom_addr);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
      end
   endtask

   // Log handshakes, pulse starts and done; check outputs hold while stalled.
   always @(negedge clk) begin
      if (done) begin
         done_n++;
         done_c = cyc;
      end
      if (rst_n) begin
         if (stall_r) begin
            hold_n++;
            check("hold", {17'd0, out_valid, out_data, out_sof, out_eof}, {17'd0, hold_w});
         end
         if (out_valid && out_ready) begin
            hs_w.push_back({out_data, out_sof, out_eof});
            hs_c.push_back(cyc);
         end
         if (rom_en && rom_addr == '0) pidx_q.push_back(int'(pulse_idx));
         stall_r = out_valid && !out_ready;
         hold_w  = {out_valid, out_data, out_sof, out_eof};
      end else begin
         stall_r = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      hs_w.delete();
      hs_c.delete();
      pidx_q.delete();
      done_n = 0;
      done_c = 0;
      hold_n = 0;
   endtask

   // Start a run and then scramble the config inputs, which must be ignored.
   task automatic launch(input logic [1:0] m, input int np, input int g, output int ts);
      mode = m;
      num_pulses = CW'(np);
      gap_cycles = CW'(g);
      start = 1'b1;
      ts = cyc;
      tick();
      start = 1'b0;
      mode = 2'd2;
      num_pulses = 16'hFFFF;
      gap_cycles = 16'd7;
   endtask

   task automatic wait_done(input int budget, input bit rnd);
      int n;
      n = 0;
      while (done_n == 0 && n < budget) begin
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         tick();
         n++;
      end
      out_ready = 1'b1;
      check("run_ends", (done_n > 0) ? 32'd1 : 32'd0, 32'd1);
      tick();
      tick();
   endtask

   task automatic wait_samples(input int want, input int budget);
      int n;
      n = 0;
      while (hs_w.size() < want && n < budget) begin
         tick();
         n++;
      end
      check("reach_samples", (hs_w.size() >= want) ? 32'd1 : 32'd0, 32'd1);
   endtask

   function automatic int cyc_at(input int i);
      return (i < hs_c.size()) ? hs_c[i] : -1000;
   endfunction

   task automatic check_pulse(input int base, input string tag);
      logic [31:0] got;
      for (int i = 0; i < D; i++) begin
         if (base + i < hs_w.size()) got = {18'd0, hs_w[base + i]};
         else got = 32'hDEAD_BEEF;
         check(tag, got, {18'd0, exp_word(i)});
      end
   endtask

   initial begin
      // Reset state
      repeat (3) tick();
      check("rst_valid", out_valid, 0);
      check("rst_rom_en", rom_en, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pidx", pulse_idx, 0);
      check("rst_data", out_data, 0);
      rst_n = 1'b1;
      tick();

      // One-shot, always ready
      clear_log();
      launch(2'd0, 5, 3, t0);
      check("os_rom_en", rom_en, 1);
      check("os_rom_addr", rom_addr, 0);
      check("os_busy", busy, 1);
      wait_done(100, 1'b0);
      check("os_count", hs_w.size(), D);
      check_pulse(0, "os_data");
      check("os_latency", cyc_at(0) - t0, 3);
      check("os_contig", cyc_at(D - 1) - cyc_at(0), D - 1);
      check("os_done_cyc", done_c, cyc_at(D - 1) + 1);
      check("os_done_n", done_n, 1);
      check("os_idle", busy, 0);

      // Burst of 3 with a 4-cycle gap
      clear_log();
      launch(2'd1, 3, 4, t0);
      wait_done(200, 1'b0);
      check("bu_count", hs_w.size(), 3 * D);
      check_pulse(0, "bu_p0");
      check_pulse(D, "bu_p1");
      check_pulse(2 * D, "bu_p2");
      check("bu_gap01", cyc_at(D) - cyc_at(D - 1), 5);
      check("bu_gap12", cyc_at(2 * D) - cyc_at(2 * D - 1), 5);
      check("bu_contig", cyc_at(2 * D - 1) - cyc_at(D), D - 1);
      check("bu_npulse", pidx_q.size(), 3);
      for (int i = 0; i < 3; i++) check("bu_pidx", (i < pidx_q.size()) ? pidx_q[i] : -1, i);
      check("bu_done_n", done_n, 1);
      check("bu_done_cyc", done_c, cyc_at(3 * D - 1) + 1);

      // Burst of 2 under random backpressure
      clear_log();
      launch(2'd1, 2, 1, t0);
      wait_done(600, 1'b1);
      check("bp_count", hs_w.size(), 2 * D);
      check_pulse(0, "bp_p0");
      check_pulse(D, "bp_p1");
      check("bp_stalls_seen", (hold_n > 0) ? 32'd1 : 32'd0, 32'd1);
      check("bp_done_n", done_n, 1);
      check("bp_done_cyc", done_c, cyc_at(2 * D - 1) + 1);

      // Continuous, back-to-back, stop in the middle of pulse 2
      clear_log();
      launch(2'd2, 0, 0, t0);
      wait_samples(2 * D + 3, 200);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      wait_done(200, 1'b0);
      check("ct_count", hs_w.size(), 3 * D);
      check_pulse(2 * D, "ct_p2");
      check("ct_b2b", cyc_at(D) - cyc_at(D - 1), 1);
      check("ct_npulse", pidx_q.size(), 3);
      check("ct_done_n", done_n, 1);

      // Reset in the middle of a pulse, then replay
      clear_log();
      launch(2'd0, 0, 0, t0);
      wait_samples(5, 100);
      rst_n = 1'b0;
      tick();
      check("mr_valid", out_valid, 0);
      check("mr_rom_en", rom_en, 0);
      check("mr_busy", busy, 0);
      check("mr_pidx", pulse_idx, 0);
      check("mr_data", {out_data, out_sof, out_eof}, 0);
      tick();
      rst_n = 1'b1;
      tick();
      check("mr_no_done", done_n, 0);
      clear_log();
      launch(2'd0, 0, 0, t0);
      wait_done(100, 1'b0);
      check("mr_count", hs_w.size(), D);
      check_pulse(0, "mr_replay");

      // num_pulses = 0 in burst mode runs one pulse
      clear_log();
      launch(2'd1, 0, 2, t0);
      wait_done(100, 1'b0);
      check("np0_count", hs_w.size(), D);
      check("np0_done_n", done_n, 1);

      // Reserved mode runs one pulse
      clear_log();
      launch(2'd3, 9, 2, t0);
      wait_done(100, 1'b0);
      check("m3_count", hs_w.size(), D);
      check("m3_done_n", done_n, 1);

      // start while busy is ignored
      clear_log();
      launch(2'd0, 0, 0, t0);
      tick();
      tick();
      mode = 2'd1;
      num_pulses = 16'd4;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(100, 1'b0);
      repeat (20) tick();
      check("sb_count", hs_w.size(), D);
      check("sb_done_n", done_n, 1);
      check("sb_idle", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1);
   end

endmodule
